// File: rtl/seg7_mux_scanner.sv
// Multiplexed 7-segment scanner: 16-phase PWM slot per digit, hex decode, one-cycle registered outputs.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_mux_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 1000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic [3:0]            brightness,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] dig_en
);

    localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [2:0]      IDX_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]      ND4      = 4'(NUM_DIGITS);
    localparam logic [6:0]      SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic            DP_OFF   = ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = ACTIVE_LOW ? '1 : '0;

    logic [PW-1:0] pre_cnt;
    logic [3:0]    phase;
    logic [2:0]    index;
    logic [3:0]    bright_q;
    // Register file is sized for the full 3-bit address space; unused entries stay at reset value.
    logic [3:0]    nib_q [8];
    logic [7:0]    dp_q;
    logic [3:0]    snap_nib;
    logic          snap_dp;
    logic          snap_blank;

    logic                  tick;
    logic [2:0]            next_index;
    logic                  next_blank;
    logic                  lit;
    logic [NUM_DIGITS-1:0] onehot;
    logic [NUM_DIGITS-1:0] dig_raw;
    logic [6:0]            seg_raw;
    logic                  dp_raw;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign tick       = (pre_cnt == PRE_LAST);
    assign next_index = (index == IDX_LAST) ? 3'd0 : index + 3'd1;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [7:0] lead_zero;

    // lead_zero[i]: digit i and every digit above it are zero with no dp.
    always_comb begin : lz_scan
        logic z;
        z         = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            z            = z && (nib_q[i] == 4'h0) && !dp_q[i];
            lead_zero[i] = z;
        end
    end

    assign next_blank = (next_index != 3'd0) && lead_zero[next_index];
`else
    assign next_blank = 1'b0;
`endif

    assign lit     = (phase < bright_q);
    assign onehot  = NUM_DIGITS'(1) << index;
    assign dig_raw = lit ? onehot : '0;
    assign seg_raw = (lit && !snap_blank) ? hex7(snap_nib) : 7'h00;
    assign dp_raw  = lit && snap_dp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt    <= '0;
            phase      <= 4'd0;
            index      <= 3'd0;
            bright_q   <= 4'd0;
            for (int i = 0; i < 8; i++) nib_q[i] <= 4'h0;
            dp_q       <= '0;
            snap_nib   <= 4'h0;
            snap_dp    <= 1'b0;
            snap_blank <= 1'b0;
            seg_out    <= SEG_OFF;
            dp_out     <= DP_OFF;
            dig_en     <= DIG_OFF;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            if (tick) begin
                phase    <= phase + 4'd1;
                bright_q <= brightness;
                // Snapshot is taken as the next slot begins, so mid-slot writes wait a full scan.
                if (phase == 4'hF) begin
                    index      <= next_index;
                    snap_nib   <= nib_q[next_index];
                    snap_dp    <= dp_q[next_index];
                    snap_blank <= next_blank;
                end
            end
            if (wr_en && ({1'b0, wr_addr} < ND4)) begin
                nib_q[wr_addr] <= wr_data;
                dp_q[wr_addr]  <= wr_dp;
            end
            seg_out <= seg_raw ^ SEG_OFF;
            dp_out  <= dp_raw ^ DP_OFF;
            dig_en  <= dig_raw ^ DIG_OFF;
        end
    end

endmodule
